// File: rtl/instruction_fetch_ctrl.sv
// Fetch controller: owns the PC driving InstructionMemory and queues {PC, instruction} in a 2-entry buffer for decode; optional range check via FETCH_BOUND_CHECK_EN.
// Latency: one edge from address to Out_*; backpressure: Out_Ready=0 fills the buffer in 2 cycles, then the PC holds.
module instruction_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic [31:0] Imem_Address,
  input  logic [31:0] Imem_Instruction,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        Halt,
  output logic        Out_Valid,
  output logic [31:0] Out_Instruction,
  output logic [31:0] Out_PC,
  input  logic        Out_Ready,
  output logic        Fault
);

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_fault;
  logic [1:0]  r_count;
  logic [31:0] r_ent0_pc;
  logic [31:0] r_ent0_ins;
  logic [31:0] r_ent1_pc;
  logic [31:0] r_ent1_ins;

  state_t      w_next_state;
  logic [31:0] w_next_pc;
  logic        w_flush;
  logic        w_push;
  logic        w_pop;
  logic        w_pop_eff;
  logic        w_space;
  logic        w_set_fault;
  logic        w_target_bad;
  logic        w_pc_oob;

  assign w_pop        = (r_count != 2'd0) && Out_Ready;
  assign w_space      = (r_count < 2'd2) || w_pop;
  assign w_target_bad = (Redirect_Target[1:0] != 2'b00) ||
                        (BOUND_EN && (Redirect_Target >= PC_LIMIT));
  assign w_pc_oob     = BOUND_EN && (r_pc >= PC_LIMIT);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_set_fault) begin
        r_fault <= 1'b1;
      end
    end
  end

  // The edge that samples Halt=0 already fetches, so leaving HALT costs no bubble.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_flush      = 1'b0;
    w_push       = 1'b0;
    w_pop_eff    = 1'b0;
    w_set_fault  = 1'b0;
    if (r_state == S_FAULT) begin
      w_next_state = S_FAULT;
    end else if (Redirect_Valid) begin
      w_flush = 1'b1;
      if (w_target_bad) begin
        w_next_state = S_FAULT;
        w_set_fault  = 1'b1;
      end else begin
        w_next_pc    = Redirect_Target;
        w_next_state = Halt ? S_HALT : S_FETCH;
      end
    end else if (Halt) begin
      w_next_state = S_HALT;
      w_pop_eff    = w_pop;
    end else begin
      w_next_state = S_FETCH;
      w_pop_eff    = w_pop;
      if (w_space) begin
        if (w_pc_oob) begin
          w_flush      = 1'b1;
          w_next_state = S_FAULT;
          w_set_fault  = 1'b1;
        end else begin
          w_push    = 1'b1;
          w_next_pc = r_pc + 32'd4;
        end
      end
    end
  end

  // Entry 0 is always the head, so Out_* come straight from flops and stay stable under backpressure.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count    <= 2'd0;
      r_ent0_pc  <= 32'd0;
      r_ent0_ins <= 32'd0;
      r_ent1_pc  <= 32'd0;
      r_ent1_ins <= 32'd0;
    end else if (w_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop_eff})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_ent0_pc  <= r_pc;
            r_ent0_ins <= Imem_Instruction;
          end else begin
            r_ent1_pc  <= r_pc;
            r_ent1_ins <= Imem_Instruction;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0_pc  <= r_ent1_pc;
          r_ent0_ins <= r_ent1_ins;
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_ent0_pc  <= r_pc;
            r_ent0_ins <= Imem_Instruction;
          end else begin
            r_ent0_pc  <= r_ent1_pc;
            r_ent0_ins <= r_ent1_ins;
            r_ent1_pc  <= r_pc;
            r_ent1_ins <= Imem_Instruction;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Imem_Address    = r_pc;
  assign Out_Valid       = (r_count != 2'd0);
  assign Out_Instruction = r_ent0_ins;
  assign Out_PC          = r_ent0_pc;
  assign Fault           = r_fault;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl: queue-based fetch model checked every cycle, plus directed literal checks.
module tb_instruction_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_WORDS = 128;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] Imem_Address;
  logic [31:0] Imem_Instruction;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        Halt;
  logic        Out_Valid;
  logic [31:0] Out_Instruction;
  logic [31:0] Out_PC;
  logic        Out_Ready;
  logic        Fault;

  logic [31:0] mem [0:IMEM_WORDS-1];

  int n_cmp  = 0;
  int n_fail = 0;

  instruction_fetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Imem_Address     (Imem_Address),
    .Imem_Instruction (Imem_Instruction),
    .Redirect_Valid   (Redirect_Valid),
    .Redirect_Target  (Redirect_Target),
    .Halt             (Halt),
    .Out_Valid        (Out_Valid),
    .Out_Instruction  (Out_Instruction),
    .Out_PC           (Out_PC),
    .Out_Ready        (Out_Ready),
    .Fault            (Fault)
  );

  assign Imem_Instruction = mem[Imem_Address[8:2]];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, instruction}, the PC, and a fault flag.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc    = RESET_PC;
  bit          m_fault = 1'b0;

  function automatic bit oob(input logic [31:0] a);
`ifdef FETCH_BOUND_CHECK_EN
    return a >= 32'(4 * IMEM_WORDS);
`else
    return (a != a);
`endif
  endfunction

  always @(posedge Clk or negedge Rst_n) begin : model
    bit pop;
    if (!Rst_n) begin
      q.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else if (!m_fault) begin
      pop = (q.size() != 0) && Out_Ready;
      if (Redirect_Valid) begin
        q.delete();
        if ((Redirect_Target[1:0] != 2'b00) || oob(Redirect_Target)) m_fault = 1'b1;
        else m_pc = Redirect_Target;
      end else begin
        if (pop) void'(q.pop_front());
        if (!Halt && q.size() < 2) begin
          if (oob(m_pc)) begin
            q.delete();
            m_fault = 1'b1;
          end else begin
            q.push_back('{pc: m_pc, ins: mem[m_pc[8:2]]});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  always @(posedge Clk) begin
    #1;
    if (Rst_n === 1'b1) begin
      chk("model_addr", Imem_Address, m_pc);
      chk("model_fault", 32'(Fault), 32'(m_fault));
      chk("model_valid", 32'(Out_Valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("model_pc", Out_PC, q[0].pc);
        chk("model_ins", Out_Instruction, q[0].ins);
      end
    end
  end

  task automatic do_reset(input logic rdy);
    Rst_n          = 1'b0;
    Out_Ready      = rdy;
    Halt           = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_Target = 32'd0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'(3 * i);
    Rst_n           = 1'b0;
    Out_Ready       = 1'b1;
    Halt            = 1'b0;
    Redirect_Valid  = 1'b0;
    Redirect_Target = 32'd0;
    #2;
    chk("rst_addr", Imem_Address, 32'h0);
    chk("rst_valid", 32'(Out_Valid), 32'd0);
    chk("rst_pc", Out_PC, 32'h0);
    chk("rst_ins", Out_Instruction, 32'h0);
    chk("rst_fault", 32'(Fault), 32'd0);

    // Streaming fetch from reset
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("stream_valid", 32'(Out_Valid), 32'd1);
      chk("stream_pc", Out_PC, 32'(4 * k));
      chk("stream_ins", Out_Instruction, 32'(3 * k));
    end

    // Backpressure: buffer fills, head and PC hold
    do_reset(1'b0);
    repeat (4) @(negedge Clk);
    chk("bp_valid", 32'(Out_Valid), 32'd1);
    chk("bp_pc", Out_PC, 32'h0);
    chk("bp_ins", Out_Instruction, 32'h0);
    chk("bp_addr", Imem_Address, 32'h8);
    Out_Ready = 1'b1;
    @(negedge Clk);
    chk("bp_rel_pc1", Out_PC, 32'h4);
    chk("bp_rel_ins1", Out_Instruction, 32'd3);
    @(negedge Clk);
    chk("bp_rel_pc2", Out_PC, 32'h8);
    chk("bp_rel_ins2", Out_Instruction, 32'd6);

    // Redirect while the buffer is full
    do_reset(1'b0);
    repeat (2) @(negedge Clk);
    chk("full_addr", Imem_Address, 32'h8);
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h40;
    @(negedge Clk);
    Redirect_Valid = 1'b0;
    Out_Ready      = 1'b1;
    chk("redir_valid", 32'(Out_Valid), 32'd0);
    chk("redir_addr", Imem_Address, 32'h40);
    @(negedge Clk);
    chk("redir_pc", Out_PC, 32'h40);
    chk("redir_ins", Out_Instruction, 32'd48);
    @(negedge Clk);
    chk("redir_pc2", Out_PC, 32'h44);
    chk("redir_ins2", Out_Instruction, 32'd51);

    // Halt at PC 0x10
    do_reset(1'b1);
    repeat (4) @(negedge Clk);
    chk("halt_pre_addr", Imem_Address, 32'h10);
    Halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("halt_addr", Imem_Address, 32'h10);
      chk("halt_valid", 32'(Out_Valid), 32'd0);
    end
    Halt = 1'b0;
    @(negedge Clk);
    chk("unhalt_pc", Out_PC, 32'h10);
    chk("unhalt_ins", Out_Instruction, 32'd12);

    // Misaligned redirect faults; async reset clears it
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h42;
    @(negedge Clk);
    Redirect_Valid = 1'b0;
    chk("fault_set", 32'(Fault), 32'd1);
    chk("fault_valid", 32'(Out_Valid), 32'd0);
    chk("fault_addr", Imem_Address, 32'h14);
    repeat (2) begin
      @(negedge Clk);
      chk("fault_hold_valid", 32'(Out_Valid), 32'd0);
      chk("fault_hold", 32'(Fault), 32'd1);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_fault", 32'(Fault), 32'd0);
    chk("arst_addr", Imem_Address, 32'h0);
    chk("arst_valid", 32'(Out_Valid), 32'd0);

    // Redirect near the top of memory
    do_reset(1'b1);
    @(negedge Clk);
    chk("top_pre_pc", Out_PC, 32'h0);
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h1FC;
    @(negedge Clk);
    Redirect_Valid = 1'b0;
    chk("top_valid", 32'(Out_Valid), 32'd0);
    chk("top_addr", Imem_Address, 32'h1FC);
    @(negedge Clk);
    chk("top_pc", Out_PC, 32'h1FC);
    chk("top_ins", Out_Instruction, 32'd381);
    @(negedge Clk);
`ifdef FETCH_BOUND_CHECK_EN
    chk("bound_fault", 32'(Fault), 32'd1);
    chk("bound_valid", 32'(Out_Valid), 32'd0);
    chk("bound_addr", Imem_Address, 32'h200);
`else
    chk("wrap_pc", Out_PC, 32'h200);
    chk("wrap_ins", Out_Instruction, 32'd0);
    chk("wrap_addr", Imem_Address, 32'h204);
    chk("wrap_fault", 32'(Fault), 32'd0);
`endif
    repeat (2) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
